// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and constants for the data-memory access controller
package dmem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_C, PORT_L} port_t;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int DEF_ADDR_W = 8;
  function automatic int max_word_addr(input int addr_w);
    return (1 << addr_w) - 4;
  endfunction
  localparam int MAX_WORD_ADDR = max_word_addr(DEF_ADDR_W);
endpackage

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: two-way arbiter, fixed priority (ARB_MODE=0) or round-robin on a last-grant pointer
module dmem_rr_arbiter
  import dmem_ctrl_pkg::*;
#(
  parameter int ARB_MODE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic c_req,
  input  logic l_req,
  output logic c_gnt,
  output logic l_gnt
);
  port_t last;
  logic pick_l;
  always_comb begin
    pick_l = l_req && (!c_req || (ARB_MODE != 0 && last == PORT_C));
    c_gnt = en && c_req && !pick_l;
    l_gnt = en && pick_l;
  end
  // reset to "L granted last" so C is favoured first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= PORT_L;
    else if (c_gnt || l_gnt) last <= l_gnt ? PORT_L : PORT_C;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrated IDLE/ACCESS/DONE sequencer for the big-endian data memory
// Define DMEM_ALIGN_CHECK_EN to also reject misaligned word accesses.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ARB_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_rw,
  input  logic              c_size,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic              c_err,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_rw,
  input  logic              l_size,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic              l_err,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] m_a,
  output logic [DATA_W-1:0] m_di,
  output logic              m_size,
  output logic              m_rw,
  output logic              m_e,
  input  logic [DATA_W-1:0] m_do
);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(max_word_addr(ADDR_W));
  state_t state, state_n;
  port_t cmd_port;
  logic grant, in_rw, in_size, misalign, in_ok, cmd_rw, cmd_ok;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata, rd;
  dmem_rr_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .en(rst_n && state == IDLE),
    .c_req(c_req),
    .l_req(l_req),
    .c_gnt(c_gnt),
    .l_gnt(l_gnt)
  );
  always_comb begin
    grant = c_gnt || l_gnt;
    in_rw = l_gnt ? l_rw : c_rw;
    in_size = l_gnt ? l_size : c_size;
    in_addr = l_gnt ? l_addr : c_addr;
    in_wdata = l_gnt ? l_wdata : c_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = |in_addr[1:0];
`else
    misalign = 1'b0;
`endif
    in_ok = !(in_size == SIZE_WORD && (in_addr > MAX_A || misalign));
    rd = (!cmd_ok || cmd_rw == RW_WRITE) ? '0 : m_size == SIZE_WORD ? m_do : DATA_W'(m_do[7:0]);
    state_n = state == IDLE ? (grant ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // memory strobes are set only on the grant edge, so they last exactly the ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_port <= PORT_C;
      cmd_rw <= 1'b0;
      cmd_ok <= 1'b0;
      m_a <= '0;
      m_di <= '0;
      m_size <= 1'b0;
      m_rw <= 1'b0;
      m_e <= 1'b0;
      c_done <= 1'b0;
      c_err <= 1'b0;
      c_rdata <= '0;
      l_done <= 1'b0;
      l_err <= 1'b0;
      l_rdata <= '0;
    end else begin
      m_rw <= 1'b0;
      m_e <= 1'b0;
      c_done <= 1'b0;
      c_err <= 1'b0;
      c_rdata <= '0;
      l_done <= 1'b0;
      l_err <= 1'b0;
      l_rdata <= '0;
      if (grant) begin
        cmd_port <= l_gnt ? PORT_L : PORT_C;
        cmd_rw <= in_rw;
        cmd_ok <= in_ok;
        m_a <= in_addr;
        m_di <= in_wdata;
        m_size <= in_size;
        m_rw <= in_ok && in_rw == RW_WRITE;
        m_e <= in_ok && in_rw == RW_WRITE;
      end
      if (state == ACCESS) begin
        c_done <= cmd_port == PORT_C;
        c_err <= cmd_port == PORT_C && !cmd_ok;
        c_rdata <= cmd_port == PORT_C ? rd : '0;
        l_done <= cmd_port == PORT_L;
        l_err <= cmd_port == PORT_L && !cmd_ok;
        l_rdata <= cmd_port == PORT_L ? rd : '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized scoreboard bench for dmem_access_ctrl against a byte-array reference memory
module tb_dmem_access_ctrl;
  localparam int ARB = 1;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct {logic err; logic [31:0] rdata; int cyc;} resp_t;
  typedef struct {logic [7:0] a; logic [31:0] d; logic sz;} wr_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic c_req = 1'b0, c_rw = 1'b0, c_size = 1'b0, l_req = 1'b0, l_rw = 1'b0, l_size = 1'b0;
  logic [7:0] c_addr = '0, l_addr = '0;
  logic [31:0] c_wdata = '0, l_wdata = '0;
  logic c_gnt, c_done, c_err, l_gnt, l_done, l_err, m_size, m_rw, m_e;
  logic [31:0] c_rdata, l_rdata, m_di, m_do;
  logic [7:0] m_a;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  resp_t cq[$], lq[$];
  wr_t wq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit last = 1'b1;
  logic m_e_prev = 1'b0;

  dmem_access_ctrl #(.ADDR_W(8), .DATA_W(32), .ARB_MODE(ARB)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_rw(c_rw), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_rw(l_rw), .l_size(l_size), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_err(l_err), .l_rdata(l_rdata),
    .m_a(m_a), .m_di(m_di), .m_size(m_size), .m_rw(m_rw), .m_e(m_e), .m_do(m_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // environment memory: big-endian, byte reads carry junk above bit 7 that the DUT must clear
  always @(posedge clk)
    if (m_e && m_rw) begin
      if (m_size) {mem[m_a], mem[m_a + 8'd1], mem[m_a + 8'd2], mem[m_a + 8'd3]} <= m_di;
      else mem[m_a] <= m_di[7:0];
    end
  always_comb m_do = m_size ? {mem[m_a], mem[m_a + 8'd1], mem[m_a + 8'd2], mem[m_a + 8'd3]} : {24'hA5A5A5, mem[m_a]};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit pl, input logic rw, input logic sz, input logic [7:0] a, input logic [31:0] d);
    resp_t r;
    wr_t w;
    r.err = sz && (a > 8'hFC || (ALIGN && a[1:0] != 2'b00));
    r.rdata = '0;
    r.cyc = cyc + 2;
    if (!r.err && rw) begin
      w.a = a; w.d = d; w.sz = sz;
      wq.push_back(w);
      if (sz) for (int i = 0; i < 4; i++) ref_mem[8'(a + i)] = d[31 - 8 * i -: 8];
      else ref_mem[a] = d[7:0];
    end else if (!r.err)
      r.rdata = sz ? {ref_mem[a], ref_mem[8'(a + 1)], ref_mem[8'(a + 2)], ref_mem[8'(a + 3)]} : {24'h0, ref_mem[a]};
    if (pl) lq.push_back(r);
    else cq.push_back(r);
    last = pl;
  endtask

  task automatic set_c(input logic rw, input logic sz, input logic [7:0] a, input logic [31:0] d);
    c_rw = rw; c_size = sz; c_addr = a; c_wdata = d;
  endtask
  task automatic set_l(input logic rw, input logic sz, input logic [7:0] a, input logic [31:0] d);
    l_rw = rw; l_size = sz; l_addr = a; l_wdata = d;
  endtask

  task automatic run(input bit ce, input bit le, input int ngr, input bit keep);
    int budget = 40;
    int prev = -1;
    int left = ngr;
    c_req = ce; l_req = le;
    while (left > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (c_gnt || l_gnt) begin
        bit wl, won_l;
        wl = (c_req && l_req) ? (ARB == 1 ? !last : 1'b0) : l_req;
        won_l = l_gnt;
        chk("gnt_onehot", 64'(c_gnt && l_gnt), 64'd0);
        chk("gnt_winner", 64'(won_l), 64'(wl));
        if (keep && prev >= 0) chk("gnt_spacing", 64'(cyc - prev), 64'd3);
        prev = cyc;
        if (won_l) model(1'b1, l_rw, l_size, l_addr, l_wdata);
        else model(1'b0, c_rw, c_size, c_addr, c_wdata);
        left--;
        @(posedge clk); #1;
        if (!keep) begin
          if (won_l) l_req = 1'b0;
          else c_req = 1'b0;
        end
      end
    end
    if (left > 0) chk("gnt_timeout", 64'(left), 64'd0);
    c_req = 1'b0; l_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_addr();
    int k = $urandom_range(0, 3);
    return k == 0 ? 8'($urandom_range(0, 31)) : k == 1 ? 8'($urandom_range(248, 255)) : k == 2 ? 8'h10 : 8'($urandom);
  endfunction

  always @(negedge clk) begin
    resp_t r;
    wr_t w;
    if (!rst_n) m_e_prev = 1'b0;
    else begin
      if (m_e) begin
        chk("strobe_single", 64'(m_e_prev), 64'd0);
        chk("strobe_rw", 64'(m_rw), 64'd1);
        if (wq.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
        else begin
          w = wq.pop_front();
          chk("m_a", 64'(m_a), 64'(w.a));
          chk("m_size", 64'(m_size), 64'(w.sz));
          chk("m_di", 64'(w.sz ? m_di : {24'h0, m_di[7:0]}), 64'(w.sz ? w.d : {24'h0, w.d[7:0]}));
        end
      end
      m_e_prev = m_e;
      if (c_done) begin
        if (cq.size() == 0) chk("unexpected_c_done", 64'd1, 64'd0);
        else begin
          r = cq.pop_front();
          chk("c_err", 64'(c_err), 64'(r.err));
          chk("c_rdata", 64'(c_rdata), 64'(r.rdata));
          chk("c_done_cycle", 64'(cyc), 64'(r.cyc));
        end
      end else chk("c_idle_quiet", 64'({c_err, c_rdata}), 64'd0);
      if (l_done) begin
        if (lq.size() == 0) chk("unexpected_l_done", 64'd1, 64'd0);
        else begin
          r = lq.pop_front();
          chk("l_err", 64'(l_err), 64'(r.err));
          chk("l_rdata", 64'(l_rdata), 64'(r.rdata));
          chk("l_done_cycle", 64'(cyc), 64'(r.cyc));
        end
      end else chk("l_idle_quiet", 64'({l_err, l_rdata}), 64'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int budget;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    c_req = 1'b1;
    l_req = 1'b1;
    #3;
    chk("rst_c", 64'({c_gnt, c_done, c_err, c_rdata}), 64'd0);
    chk("rst_l", 64'({l_gnt, l_done, l_err, l_rdata}), 64'd0);
    chk("rst_m", 64'({m_a, m_size, m_rw, m_e}), 64'd0);
    chk("rst_mdi", 64'(m_di), 64'd0);
    c_req = 1'b0;
    l_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_c(1'b1, 1'b1, 8'h10, 32'hDEADBEEF); run(1'b1, 1'b0, 1, 1'b0);
    set_c(1'b0, 1'b1, 8'h10, 32'h0); run(1'b1, 1'b0, 1, 1'b0);
    set_c(1'b0, 1'b0, 8'h11, 32'h0); run(1'b1, 1'b0, 1, 1'b0);
    set_c(1'b0, 1'b1, 8'hFD, 32'h0); run(1'b1, 1'b0, 1, 1'b0);
    set_c(1'b0, 1'b1, 8'hFC, 32'h0); run(1'b1, 1'b0, 1, 1'b0);
    set_c(1'b0, 1'b0, 8'hFF, 32'h0); run(1'b1, 1'b0, 1, 1'b0);
    set_l(1'b1, 1'b1, 8'h12, 32'h11223344); run(1'b0, 1'b1, 1, 1'b0);
    set_l(1'b0, 1'b1, 8'h10, 32'h0); run(1'b0, 1'b1, 1, 1'b0);
    set_c(1'b0, 1'b1, 8'h20, 32'h0);
    set_l(1'b0, 1'b0, 8'h21, 32'h0);
    run(1'b1, 1'b1, 4, 1'b1);
    for (int t = 0; t < 60; t++) begin
      int mode = $urandom_range(0, 2);
      set_c(1'($urandom), 1'($urandom), rnd_addr(), $urandom);
      set_l(1'($urandom), 1'($urandom), rnd_addr(), $urandom);
      run(mode != 1, mode != 0, mode == 2 ? 2 : 1, 1'b0);
    end
    set_c(1'b1, 1'b1, 8'h30, 32'hCAFEF00D);
    c_req = 1'b1;
    budget = 10;
    do begin
      @(negedge clk);
      budget--;
    end while (!c_gnt && budget > 0);
    chk("rst_mid_gnt", 64'(c_gnt), 64'd1);
    @(posedge clk); #1;
    c_req = 1'b0;
    chk("rst_mid_strobe_on", 64'({m_e, m_rw}), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobe_off", 64'({m_e, m_rw}), 64'd0);
    chk("rst_mid_c_out", 64'({c_done, c_err, c_rdata}), 64'd0);
    last = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    set_c(1'b0, 1'b1, 8'h30, 32'h0); run(1'b1, 1'b0, 1, 1'b0);
    chk("cq_drained", 64'(cq.size()), 64'd0);
    chk("lq_drained", 64'(lq.size()), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
